alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares one combinational 8-bit ALU (add / invert-B / AND / OR, with signed-overflow flag) between two requesters.
- Uses round-robin arbitration and a valid/ready request and response handshake.
- Registers operands before the ALU and results after it, giving a fixed-latency, glitch-free interface.
- Sits between the lab's front-end stimulus/controller logic and the ALU datapath. Keeps a saturating count of overflow events.

Parameters:
- WIDTH, 8, operand/result width (ALU is defined for 8; other values unsupported).
- CNT_W, 8, width of the overflow event counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req_ready  out  2  per-requester grant/accept, one-hot or zero.
- req0_a, req0_b  in  WIDTH each  requester 0 operands.
- req0_sel  in  2  requester 0 opcode.
- req1_a, req1_b  in  WIDTH each  requester 1 operands.
- req1_sel  in  2  requester 1 opcode.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  requester that owns the result.
- rsp_f  out  WIDTH  ALU result.
- rsp_ovf  out  1  signed overflow (add only).
- ovf_count  out  CNT_W  saturating count of results with ovf=1.

Behaviour:
- Opcodes:
  - 00: f=a+b mod 2^8; ovf=(a[7]^f[7])&(b[7]^f[7]).
  - 01: f=~b; ovf=0.
  - 10: f=a&b; ovf=0.
  - 11: f=a|b; ovf=0.
- Reset: state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_f=0, rsp_ovf=0, ovf_count=0, last_grant=1 (requester 0 wins the first tie). Operand regs cleared to 0.
- FSM states:
  - IDLE:
    - req_ready is combinational from state, req_valid and last_grant.
    - Only one requester valid: grant it.
    - Both valid: grant the one != last_grant.
    - On grant: req_ready[i]=1 this cycle, latch a/b/sel/id into operand regs, last_grant<=i, go EXEC.
    - No valid: stay.
  - EXEC (1 cycle):
    - ALU sees registered operands; capture f, ovf, id into response regs.
    - If ovf=1 and ovf_count != all-ones, ovf_count++.
    - Go RESP.
  - RESP:
    - rsp_valid=1; rsp_* held stable.
    - rsp_ready=1 → rsp_valid<=0 next cycle, go IDLE.
    - Otherwise stay; no new grants while in RESP.
- Latency: grant in cycle T → rsp_valid high at T+2. Minimum 3 cycles per operation (new grant possible in the cycle after the response handshake).
- req_ready is never asserted outside IDLE and never to both requesters. A requester must hold its operands stable while req_valid=1 until req_ready=1. Dropping req_valid before grant is legal and has no effect.
- ovf_count saturates at 2^CNT_W-1 and never wraps. Cleared only by rst.
- rst asserted in any state (including EXEC/RESP) aborts the operation: the pending result is discarded, no response is produced, and all reset values apply the next cycle.
- rst has priority over all other events in the same cycle.

Decomposition:
- Shared package holds:
  - Opcode constants OP_ADD=2'b00, OP_NOTB=2'b01, OP_AND=2'b10, OP_OR=2'b11.
  - FSM state encoding ST_IDLE, ST_EXEC, ST_RESP.
- One natural sub-module: alu8_core. It is purely combinational (a, b, sel → f, ovf) per the opcode rules above, and is instantiated once, fed by the operand regs.

Test Plan:
- Req0 only, a=0x07, b=0x64, sel=00 → rsp_valid at T+2, rsp_id=0, rsp_f=0x6B, rsp_ovf=0, ovf_count=0.
- Req1 only, a=0x50, b=0x5A, sel=00 → rsp_f=0xAA, rsp_ovf=1, rsp_id=1, ovf_count=1.
- Both valid continuously from reset: req0 sel=01, b=0x5A; req1 sel=10, a=0x8F, b=0x95 → grants alternate 0,1,0. Results 0xA5 (id 0), 0x85 (id 1). req_ready never two-hot.
- rsp_ready held low 5 cycles with req0 sel=11, a=0xAF, b=0x95 → rsp_valid and rsp_f=0xBF held stable. req_ready stays 0 despite pending req1. Handshake completes when rsp_ready=1.
- rst pulsed during EXEC → next cycle rsp_valid=0, state IDLE, ovf_count=0. Aborted result never appears. Subsequent request behaves as first after reset (requester 0 wins tie).
- 300 back-to-back overflowing adds (0x7F+0x01) → ovf_count reaches 0xFF and stays 0xFF.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: opcodes and FSM state encoding shared by the ALU arbiter
package alu_arbiter_pkg;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_NOTB = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_OR   = 2'b11;
    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_e;
endpackage

// File: rtl/alu8_core.sv
// alu8_core: combinational add / invert-B / AND / OR with signed overflow on add
module alu8_core
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       sel_i,
    output logic [WIDTH-1:0] f_o,
    output logic             ovf_o
);
    logic [WIDTH-1:0] sum;
    assign sum = a_i + b_i;
    // overflow only when both operands disagree in sign with the sum
    always_comb begin
        f_o   = sel_i == OP_ADD  ? sum :
                sel_i == OP_NOTB ? ~b_i :
                sel_i == OP_AND  ? a_i & b_i : a_i | b_i;
        ovf_o = (sel_i == OP_ADD) & (a_i[WIDTH-1] ^ sum[WIDTH-1]) & (b_i[WIDTH-1] ^ sum[WIDTH-1]);
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one registered ALU between two requesters
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_sel,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_f,
    output logic             rsp_ovf,
    output logic [CNT_W-1:0] ovf_count
);
    state_e           state_q, state_d;
    logic             last_q;
    logic [1:0]       gnt;
    logic [WIDTH-1:0] a_q, b_q, f_q;
    logic [1:0]       sel_q;
    logic             id_q, rid_q, ovf_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] alu_f;
    logic             alu_ovf;

    alu8_core #(.WIDTH(WIDTH)) u_alu (
        .a_i   (a_q),
        .b_i   (b_q),
        .sel_i (sel_q),
        .f_o   (alu_f),
        .ovf_o (alu_ovf)
    );

    // grant only in IDLE; on a tie the requester not granted last time wins
    always_comb begin
        gnt     = 2'b00;
        state_d = state_q;
        if (state_q == ST_IDLE)
            gnt = req_valid == 2'b11 ? (last_q ? 2'b01 : 2'b10) : req_valid;
        state_d = state_q == ST_IDLE ? (|gnt ? ST_EXEC : ST_IDLE) :
                  state_q == ST_EXEC ? ST_RESP :
                  rsp_ready ? ST_IDLE : ST_RESP;
    end

    // operand capture on grant, result capture in EXEC, saturating overflow count
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            id_q    <= 1'b0;
            f_q     <= '0;
            ovf_q   <= 1'b0;
            rid_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (|gnt) begin
                a_q    <= gnt[1] ? req1_a : req0_a;
                b_q    <= gnt[1] ? req1_b : req0_b;
                sel_q  <= gnt[1] ? req1_sel : req0_sel;
                id_q   <= gnt[1];
                last_q <= gnt[1];
            end
            if (state_q == ST_EXEC) begin
                f_q   <= alu_f;
                ovf_q <= alu_ovf;
                rid_q <= id_q;
                if (alu_ovf && !(&cnt_q))
                    cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign req_ready = gnt;
    assign rsp_valid = state_q == ST_RESP;
    assign rsp_id    = rid_q;
    assign rsp_f     = f_q;
    assign rsp_ovf   = ovf_q;
    assign ovf_count = cnt_q;
endmodule
